// File: rtl/station_scheduler_pkg.sv
// rtl/station_scheduler_pkg.sv - shared field widths, station field record and one-hot encoder for the station scheduler
package station_scheduler_pkg;

  localparam int NUM_ST_DEF = 4;
  localparam int REG_W      = 3;
  localparam int DADR_W     = 4;
  localparam int DADR_WE    = 3;
  localparam int LOCK_W     = 4;
  localparam int LOCK_V     = 3;

  typedef struct packed {
    logic [REG_W-1:0] a_adr;
    logic [REG_W-1:0] b_adr;
    logic             d_we;
    logic [REG_W-1:0] d_adr;
    logic             lock_v;
    logic [REG_W-1:0] lock_adr;
  } st_fields_t;

  function automatic logic [2:0] onehot_idx(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (v[i]) r = 3'(i);
    return r;
  endfunction

endpackage

// File: rtl/sched_age_matrix.sv
// rtl/sched_age_matrix.sv - per-station age flops updated on dispatch, and oldest-candidate select
module sched_age_matrix #(
  parameter int NUM_ST = 4
) (
  input  logic                     clk,
  input  logic                     a_rst,
  input  logic [NUM_ST-1:0]        feed,
  input  logic [NUM_ST-1:0]        free,
  input  logic [NUM_ST-1:0]        cand,
  output logic [NUM_ST-1:0]        grant,
  output logic [NUM_ST*NUM_ST-1:0] age_flat
);

  // age[i][j] = 1 : station j is older than station i
  logic [NUM_ST-1:0] age [NUM_ST];
  logic [NUM_ST-1:0] oldest;

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      for (int i = 0; i < NUM_ST; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ST; i++)
        for (int j = 0; j < NUM_ST; j++)
          if (i == j)       age[i][j] <= 1'b0;
          else if (feed[i]) age[i][j] <= ~free[j];
          else if (feed[j]) age[i][j] <= 1'b0;
    end
  end

  // Equal ages (fresh after reset) can leave several "oldest"; lowest index breaks the tie.
  always_comb begin
    oldest = '0;
    grant  = '0;
    for (int i = 0; i < NUM_ST; i++)
      oldest[i] = cand[i] & ~|(cand & age[i]);
    for (int i = NUM_ST - 1; i >= 0; i--)
      if (oldest[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
  end

  for (genvar g = 0; g < NUM_ST; g++) begin : g_flat
    assign age_flat[g*NUM_ST +: NUM_ST] = age[g];
  end

endmodule

// File: rtl/station_scheduler.sv
// rtl/station_scheduler.sv - reservation-station dispatch, hazard-aware oldest-first issue; SCHED_STATS_EN adds issue/hazard counters
module station_scheduler
  import station_scheduler_pkg::*;
#(
  parameter int NUM_ST = NUM_ST_DEF,
  parameter int IDX_W  = $clog2(NUM_ST)
) (
  input  logic                       clk,
  input  logic                       a_rst,
  input  logic                       id_valid,
  output logic                       id_stall,
  output logic [NUM_ST-1:0]          st_feed,
  input  logic [NUM_ST-1:0]          st_free,
  input  logic [NUM_ST-1:0]          st_ready,
  input  logic [NUM_ST*REG_W-1:0]    st_a_adr,
  input  logic [NUM_ST*REG_W-1:0]    st_b_adr,
  input  logic [NUM_ST*DADR_W-1:0]   st_d_adr,
  input  logic [NUM_ST-1:0]          st_ld_mem,
  input  logic [NUM_ST-1:0]          st_lock_loads,
  input  logic [NUM_ST*LOCK_W-1:0]   st_lock_reg_wr,
  output logic [NUM_ST-1:0]          st_ack,
  input  logic                       ex_stall,
  output logic                       iss_valid,
  output logic [IDX_W-1:0]           iss_sel
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]                stat_issue,
  output logic [15:0]                stat_hazard
`endif
);

  st_fields_t                 fld [NUM_ST];
  logic [NUM_ST-1:0]          lowest_free;
  logic [NUM_ST-1:0]          blocked;
  logic [NUM_ST-1:0]          cand;
  logic [NUM_ST-1:0]          grant;
  logic [NUM_ST*NUM_ST-1:0]   age_flat;

  for (genvar g = 0; g < NUM_ST; g++) begin : g_fld
    assign fld[g].a_adr    = st_a_adr[g*REG_W +: REG_W];
    assign fld[g].b_adr    = st_b_adr[g*REG_W +: REG_W];
    assign fld[g].d_we     = st_d_adr[g*DADR_W + DADR_WE];
    assign fld[g].d_adr    = st_d_adr[g*DADR_W +: REG_W];
    assign fld[g].lock_v   = st_lock_reg_wr[g*LOCK_W + LOCK_V];
    assign fld[g].lock_adr = st_lock_reg_wr[g*LOCK_W +: REG_W];
  end

  always_comb begin
    lowest_free = '0;
    for (int i = NUM_ST - 1; i >= 0; i--)
      if (st_free[i]) begin
        lowest_free    = '0;
        lowest_free[i] = 1'b1;
      end
  end

  assign st_feed  = id_valid ? lowest_free : '0;
  assign id_stall = id_valid & ~|st_free;

  // RAW / WAW against an older station's pending register write, plus load-after-store ordering.
  always_comb begin
    blocked = '0;
    for (int i = 0; i < NUM_ST; i++)
      for (int j = 0; j < NUM_ST; j++)
        if (j != i && age_flat[i*NUM_ST + j] && !st_free[j]) begin
          if (fld[j].lock_v && (fld[j].lock_adr == fld[i].a_adr ||
                                fld[j].lock_adr == fld[i].b_adr))
            blocked[i] = 1'b1;
          if (fld[j].lock_v && fld[i].d_we && fld[i].d_adr == fld[j].lock_adr)
            blocked[i] = 1'b1;
          if (st_ld_mem[i] && st_lock_loads[j])
            blocked[i] = 1'b1;
        end
  end

  assign cand = st_ready & ~blocked;

  sched_age_matrix #(.NUM_ST(NUM_ST)) u_age (
    .clk      (clk),
    .a_rst    (a_rst),
    .feed     (st_feed),
    .free     (st_free),
    .cand     (cand),
    .grant    (grant),
    .age_flat (age_flat)
  );

  assign st_ack = grant & {NUM_ST{~ex_stall}};

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      iss_valid <= 1'b0;
      iss_sel   <= '0;
    end else begin
      iss_valid <= |st_ack;
      iss_sel   <= IDX_W'(onehot_idx(8'(st_ack)));
    end
  end

`ifdef SCHED_STATS_EN
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      stat_issue  <= '0;
      stat_hazard <= '0;
    end else begin
      if (|st_ack && stat_issue != 16'hffff)
        stat_issue <= stat_issue + 16'd1;
      if (|st_ready && ~|grant && stat_hazard != 16'hffff)
        stat_hazard <= stat_hazard + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_station_scheduler.sv
// tb/tb_station_scheduler.sv - directed corner cases plus random dispatch/issue scored against a timestamp model
module tb_station_scheduler;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           a_rst;
  logic           id_valid;
  logic           id_stall;
  logic [N-1:0]   st_feed;
  logic [N-1:0]   st_free;
  logic [N-1:0]   st_ready;
  logic [N*3-1:0] st_a_adr;
  logic [N*3-1:0] st_b_adr;
  logic [N*4-1:0] st_d_adr;
  logic [N-1:0]   st_ld_mem;
  logic [N-1:0]   st_lock_loads;
  logic [N*4-1:0] st_lock_reg_wr;
  logic [N-1:0]   st_ack;
  logic           ex_stall;
  logic           iss_valid;
  logic [1:0]     iss_sel;
`ifdef SCHED_STATS_EN
  logic [15:0]    stat_issue;
  logic [15:0]    stat_hazard;
`endif

  station_scheduler #(.NUM_ST(N), .IDX_W(2)) dut (
    .clk            (clk),
    .a_rst          (a_rst),
    .id_valid       (id_valid),
    .id_stall       (id_stall),
    .st_feed        (st_feed),
    .st_free        (st_free),
    .st_ready       (st_ready),
    .st_a_adr       (st_a_adr),
    .st_b_adr       (st_b_adr),
    .st_d_adr       (st_d_adr),
    .st_ld_mem      (st_ld_mem),
    .st_lock_loads  (st_lock_loads),
    .st_lock_reg_wr (st_lock_reg_wr),
    .st_ack         (st_ack),
    .ex_stall       (ex_stall),
    .iss_valid      (iss_valid),
    .iss_sel        (iss_sel)
`ifdef SCHED_STATS_EN
    ,
    .stat_issue     (stat_issue),
    .stat_hazard    (stat_hazard)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  bit mon_en = 1'b0;

  logic [2:0] a   [N];
  logic [2:0] b   [N];
  logic [3:0] d   [N];
  logic [3:0] lk  [N];
  logic       ldm [N];
  logic       lkl [N];
  logic       rdy [N];
  bit         busy [N];
  int         stamp [N];
  int         tick = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      st_a_adr[i*3 +: 3]       = a[i];
      st_b_adr[i*3 +: 3]       = b[i];
      st_d_adr[i*4 +: 4]       = d[i];
      st_lock_reg_wr[i*4 +: 4] = lk[i];
      st_ld_mem[i]             = ldm[i];
      st_lock_loads[i]         = lkl[i];
      st_ready[i]              = rdy[i];
    end
  endtask

  task automatic clear_fields();
    for (int i = 0; i < N; i++) begin
      a[i] = '0; b[i] = '0; d[i] = '0; lk[i] = '0;
      ldm[i] = 1'b0; lkl[i] = 1'b0; rdy[i] = 1'b0;
    end
  endtask

  // Older = occupied and dispatched earlier; any hazard against an older occupant blocks.
  function automatic bit model_blocked(input int i);
    for (int j = 0; j < N; j++) begin
      if (j == i || !busy[j] || stamp[j] >= stamp[i]) continue;
      if (lk[j][3] && (lk[j][2:0] == a[i] || lk[j][2:0] == b[i])) return 1'b1;
      if (lk[j][3] && d[i][3] && d[i][2:0] == lk[j][2:0]) return 1'b1;
      if (ldm[i] && lkl[j]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int model_pick();
    int best = -1;
    for (int i = 0; i < N; i++)
      if (busy[i] && rdy[i] && !model_blocked(i) && (best < 0 || stamp[i] < stamp[best]))
        best = i;
    return best;
  endfunction

  always @(posedge clk) begin
    #1;
    if (mon_en && !a_rst && iss_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL iss_unexpected actual=sel%0d required=no_issue", iss_sel);
      end else begin
        chk("iss_sel", 32'(iss_sel), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int k, g;
    logic [N-1:0] exp_feed, exp_ack;
    logic         exp_stall;

    a_rst = 1'b1; id_valid = 1'b0; ex_stall = 1'b0; st_free = '0;
    clear_fields(); drive();
    repeat (2) @(negedge clk);
    chk("rst_iss_valid", 32'(iss_valid), 32'd0);
    chk("rst_iss_sel", 32'(iss_sel), 32'd0);
    a_rst = 1'b0;

    st_free = 4'b1111; id_valid = 1'b1; drive(); #1;
    chk("all_free_feed", 32'(st_feed), 32'h1);
    chk("all_free_stall", 32'(id_stall), 32'd0);
    chk("all_free_ack", 32'(st_ack), 32'd0);

    @(negedge clk); st_free = 4'b1100; #1;
    chk("feed_st2", 32'(st_feed), 32'h4);

    @(negedge clk); st_free = 4'b1010; id_valid = 1'b0;
    rdy[0] = 1'b1; rdy[2] = 1'b1; drive(); #1;
    chk("older_wins_ack", 32'(st_ack), 32'h1);
    @(posedge clk); #1;
    chk("iss_valid_after_ack", 32'(iss_valid), 32'd1);
    chk("iss_sel_after_ack", 32'(iss_sel), 32'd0);

    @(negedge clk); rdy[0] = 1'b0; lk[0] = 4'b1011; a[2] = 3'd3; drive(); #1;
    chk("raw_blocked_ack", 32'(st_ack), 32'd0);
    @(posedge clk); #1;
    chk("blocked_iss_valid", 32'(iss_valid), 32'd0);

    @(negedge clk); lk[0] = 4'b0011; drive(); #1;
    chk("unblocked_ack", 32'(st_ack), 32'h4);

    @(negedge clk); rdy[2] = 1'b0; rdy[0] = 1'b1; ex_stall = 1'b1; drive(); #1;
    chk("ex_stall_ack", 32'(st_ack), 32'd0);
    @(posedge clk); #1;
    chk("ex_stall_iss_valid", 32'(iss_valid), 32'd0);
    @(negedge clk); ex_stall = 1'b0; #1;
    chk("stall_release_ack", 32'(st_ack), 32'h1);

    @(negedge clk); st_free = 4'b0000; id_valid = 1'b1; #1;
    chk("full_stall", 32'(id_stall), 32'd1);
    chk("full_feed", 32'(st_feed), 32'd0);
    @(posedge clk); #1;
    chk("pre_rst_iss_valid", 32'(iss_valid), 32'd1);
    #2 a_rst = 1'b1; #1;
    chk("async_rst_iss_valid", 32'(iss_valid), 32'd0);

    @(negedge clk);
    id_valid = 1'b0; st_free = 4'b1111; clear_fields(); drive();
    for (int i = 0; i < N; i++) begin busy[i] = 1'b0; stamp[i] = 0; end
    @(negedge clk); a_rst = 1'b0; mon_en = 1'b1;

    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      id_valid = ($urandom_range(0, 9) < 6);
      ex_stall = ($urandom_range(0, 9) < 2);
      for (int i = 0; i < N; i++) begin
        a[i]   = 3'($urandom_range(0, 3));
        b[i]   = 3'($urandom_range(0, 3));
        d[i]   = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 3))};
        lk[i]  = {1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 3))};
        ldm[i] = ($urandom_range(0, 9) < 4);
        lkl[i] = ($urandom_range(0, 3) == 0);
        rdy[i] = busy[i] && ($urandom_range(0, 9) < 7);
        st_free[i] = ~busy[i];
      end
      drive(); #1;

      k = -1;
      for (int i = N - 1; i >= 0; i--) if (!busy[i]) k = i;
      exp_feed  = '0;
      if (id_valid && k >= 0) exp_feed[k] = 1'b1;
      exp_stall = id_valid && (k < 0);
      g = ex_stall ? -1 : model_pick();
      exp_ack = '0;
      if (g >= 0) begin
        exp_ack[g] = 1'b1;
        exp_q.push_back(g);
      end
      chk("rnd_feed", 32'(st_feed), 32'(exp_feed));
      chk("rnd_stall", 32'(id_stall), 32'(exp_stall));
      chk("rnd_ack", 32'(st_ack), 32'(exp_ack));

      @(posedge clk);
      if (id_valid && k >= 0) begin
        busy[k]  = 1'b1;
        stamp[k] = tick;
        tick++;
      end
      if (g >= 0 && $urandom_range(0, 1) == 1) busy[g] = 1'b0;
    end

    @(negedge clk); id_valid = 1'b0; for (int i = 0; i < N; i++) rdy[i] = 1'b0; drive();
    repeat (3) @(negedge clk);
    chk("issue_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
